// File: rtl/swish_ctrl_pkg.sv
// Shared types and helpers for the swish stream controller.
// Holds the FSM state encoding and counter width calculation.
package swish_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_lazy_fork2.sv
// Two-way lazy stream fork: each branch takes a beat exactly once.
// Taken flags remember branches already served until the beat retires.
module stream_lazy_fork2 (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic valid_i,
  output logic ready_o,
  output logic a_valid_o,
  input  logic a_ready_i,
  output logic b_valid_o,
  input  logic b_ready_i
);

  logic taken_a_q, taken_a_d;
  logic taken_b_q, taken_b_d;
  logic beat;

  assign a_valid_o = valid_i & en_i & ~taken_a_q;
  assign b_valid_o = valid_i & en_i & ~taken_b_q;
  assign ready_o   = en_i
                   & (a_ready_i | taken_a_q)
                   & (b_ready_i | taken_b_q);
  assign beat      = valid_i & ready_o;

  always_comb begin
    taken_a_d = taken_a_q | (a_valid_o & a_ready_i);
    taken_b_d = taken_b_q | (b_valid_o & b_ready_i);
    if (beat) begin
      taken_a_d = 1'b0;
      taken_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_a_q <= 1'b0;
      taken_b_q <= 1'b0;
    end else begin
      taken_a_q <= taken_a_d;
      taken_b_q <= taken_b_d;
    end
  end

endmodule

// File: rtl/fixed_swish_stream_ctrl.sv
// Swish pass sequencer: forks input beats to sigmoid and bypass paths,
// bounds in-flight beats with credits and tracks end of tensor.
module fixed_swish_stream_ctrl
  import swish_ctrl_pkg::*;
#(
  parameter int TOTAL_BEATS  = 10,
  parameter int MAX_INFLIGHT = 10,
  parameter int CNT_W        = cnt_width(TOTAL_BEATS),
  parameter int CRD_W        = cnt_width(MAX_INFLIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             fork_a_valid,
  input  logic             fork_a_ready,
  output logic             fork_b_valid,
  input  logic             fork_b_ready,
  input  logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CRD_W-1:0] inflight
);

  localparam logic [CNT_W-1:0] TOT  = CNT_W'(TOTAL_BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL_BEATS - 1);
  localparam logic [CRD_W-1:0] CMAX = CRD_W'(MAX_INFLIGHT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CRD_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             accept_en, beat, ohs;

  assign accept_en = (state_q == RUN) && (inflight_q < CMAX);
  assign beat      = in_valid & in_ready;
  assign ohs       = out_valid & out_ready;

  stream_lazy_fork2 u_fork (
    .clk       (clk),
    .rst       (rst),
    .en_i      (accept_en),
    .valid_i   (in_valid),
    .ready_o   (in_ready),
    .a_valid_o (fork_a_valid),
    .a_ready_i (fork_a_ready),
    .b_valid_o (fork_b_valid),
    .b_ready_i (fork_b_ready)
  );

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      RUN: begin
        if (beat) in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_d == TOT) state_d = DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && ohs && out_cnt_q != TOT)
      out_cnt_d = out_cnt_q + 1'b1;
    // An early final output still spends one cycle in DRAIN.
    if (state_q == DRAIN && out_cnt_d == TOT) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    unique case ({beat, ohs})
      2'b10: inflight_d = inflight_q + 1'b1;
      2'b01: begin
        if (inflight_q == '0) err_d = 1'b1;
        else inflight_d = inflight_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign out_last = busy & (out_cnt_q == LAST);
  assign inflight = inflight_q;

endmodule

// File: tb/tb_fixed_swish_stream_ctrl.sv
// Bench for fixed_swish_stream_ctrl: directed scenarios plus random
// traffic, all checked each cycle against a behavioural model.
module tb_fixed_swish_stream_ctrl;

  localparam int TOTAL = 10;
  localparam int MAXI  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       fork_a_valid, fork_b_valid;
  logic       fork_a_ready = 1'b0;
  logic       fork_b_ready = 1'b0;
  logic       out_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic [2:0] inflight;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: phase 0 idle, 1 accepting, 2 waiting for outputs.
  int m_ph = 0, m_in = 0, m_out = 0, m_cred = 0;
  bit m_err = 0, m_done = 0, m_ta = 0, m_tb = 0;
  bit o_ir, o_done;

  always #5 clk = ~clk;

  fixed_swish_stream_ctrl #(
    .TOTAL_BEATS  (TOTAL),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fork_a_valid (fork_a_valid),
    .fork_a_ready (fork_a_ready),
    .fork_b_valid (fork_b_valid),
    .fork_b_ready (fork_b_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .inflight     (inflight)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_in = 0; m_out = 0; m_cred = 0;
    m_err = 0; m_done = 0; m_ta = 0; m_tb = 0;
  endtask

  // One clock cycle: drive, check outputs, advance the model.
  task automatic cyc(input bit st, iv, ar, br, ov, ordy);
    bit acc, fav, fbv, ir, beat, ohs;
    @(negedge clk);
    start = st; in_valid = iv;
    fork_a_ready = ar; fork_b_ready = br;
    out_valid = ov; out_ready = ordy;
    #1;
    acc  = (m_ph == 1) && (m_cred < MAXI);
    fav  = iv && acc && !m_ta;
    fbv  = iv && acc && !m_tb;
    ir   = acc && (ar || m_ta) && (br || m_tb);
    beat = iv && ir;
    ohs  = ov && ordy;
    o_ir = in_ready;
    o_done = done;
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
    chk("in_ready", int'(in_ready), int'(ir));
    chk("fork_a_valid", int'(fork_a_valid), int'(fav));
    chk("fork_b_valid", int'(fork_b_valid), int'(fbv));
    chk("out_last", int'(out_last),
        int'(m_ph != 0 && m_out == TOTAL - 1));
    chk("inflight", int'(inflight), m_cred);
    m_done = 0;
    if (m_ph == 0) begin
      if (st) begin
        m_ph = 1; m_in = 0; m_out = 0; m_err = 0;
      end
    end else begin
      if (beat) m_in++;
      if (ohs && m_out < TOTAL) m_out++;
      if (m_ph == 2 && m_out == TOTAL) begin
        m_ph = 0; m_done = 1;
      end else if (m_ph == 1 && m_in == TOTAL) begin
        m_ph = 2;
      end
    end
    if (beat && !ohs) m_cred++;
    else if (ohs && !beat) begin
      if (m_cred == 0) m_err = 1;
      else m_cred--;
    end
    if (beat) begin
      m_ta = 0; m_tb = 0;
    end else begin
      if (fav && ar) m_ta = 1;
      if (fbv && br) m_tb = 1;
    end
  endtask

  task automatic hit_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fav", int'(fork_a_valid), 0);
    chk("rst_fbv", int'(fork_b_valid), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    model_reset();
    start = 0; in_valid = 0; out_valid = 0;
    fork_a_ready = 0; fork_b_ready = 0; out_ready = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Complete a tensor; outputs return 3 cycles after each beat.
  task automatic run_tensor(output int n_ir, output int n_done);
    int q[$];
    int t;
    bit ov;
    n_ir = 0; n_done = 0; t = 0;
    cyc(1, 0, 1, 1, 0, 1);
    while (t < 60 && n_done == 0) begin
      ov = (q.size() > 0) && (q[0] <= t);
      cyc(0, m_ph == 1 && m_in < TOTAL, 1, 1, ov, 1);
      if (ov) void'(q.pop_front());
      if (o_ir && in_valid) begin
        q.push_back(t + 3);
        n_ir++;
      end
      if (o_done) n_done++;
      t++;
    end
    chk("tensor_timeout", int'(t < 60), 1);
  endtask

  // Finish whatever tensor is open, returning credits promptly.
  task automatic finish_tensor();
    int t;
    t = 0;
    while (t < 80 && (m_ph != 0 || m_done)) begin
      cyc(0, m_ph == 1 && m_in < TOTAL, 1, 1, m_cred > 0, 1);
      t++;
    end
    chk("finish_timeout", int'(t < 80), 1);
  endtask

  initial begin
    int nir, ndn, cnt, t;
    bit hold, iv, ov;

    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_inflight", int'(inflight), 0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back tensor with delayed outputs.
    run_tensor(nir, ndn);
    chk("t1_in_ready_cnt", nir, TOTAL);
    chk("t1_done_cnt", ndn, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_inflight_end", int'(inflight), 0);

    // Skewed branches: A served first, B later.
    cyc(1, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      if (o_ir) cnt++;
    end
    cyc(0, 1, 1, 1, 0, 0);
    if (o_ir) cnt++;
    chk("t2_beats", cnt, 1);
    hit_reset();

    // Credit full: 4 beats then stall; freed credit usable next cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 1, 0, 0);
      if (o_ir) cnt++;
    end
    chk("t3_accepted", cnt, MAXI);
    cyc(0, 1, 1, 1, 1, 1);
    chk("t3_same_cycle", int'(o_ir), 0);
    cyc(0, 1, 1, 1, 0, 0);
    chk("t3_next_cycle", int'(o_ir), 1);
    hit_reset();

    // Simultaneous accept and output handshake.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_inflight", int'(inflight), 1);
    hit_reset();

    // Reset mid-tensor with taken_b set, then a clean tensor.
    cyc(1, 0, 0, 0, 0, 0);
    cnt = 0; t = 0;
    while (cnt < 5 && t < 30) begin
      cyc(0, 1, 1, 1, m_cred > 0, 1);
      if (o_ir) cnt++;
      t++;
    end
    chk("t5_pre_beats", cnt, 5);
    cyc(0, 1, 0, 1, 0, 0);
    @(negedge clk);
    in_valid = 1; fork_a_ready = 0; fork_b_ready = 1;
    #1;
    chk("t5_fb_dropped", int'(fork_b_valid), 0);
    hit_reset();
    run_tensor(nir, ndn);
    chk("t5_in_ready_cnt", nir, TOTAL);
    chk("t5_done_cnt", ndn, 1);

    // Error on credit underflow, sticky until the next start.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_err_sticky", int'(err), 1);
    cyc(1, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 1, 0, 0);
      if (o_ir) cnt++;
    end
    chk("t6_err_cleared", int'(err), 0);
    chk("t6_busy_start_beats", cnt, 3);
    finish_tensor();

    // Random traffic.
    for (int r = 0; r < 8; r++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        cyc(0, 0, 0, 0, ($urandom % 8) == 0, 1);
      cyc(1, 0, 0, 0, 0, 0);
      hold = 0; t = 0;
      while (t < 400 && (m_ph != 0 || m_done)) begin
        iv = hold || ($urandom % 4 != 0);
        ov = (m_cred > 0) ? bit'($urandom % 2) : ($urandom % 20 == 0);
        cyc(($urandom % 20) == 0, iv,
            $urandom % 3 != 0, $urandom % 3 != 0,
            ov, $urandom % 10 < 7);
        hold = iv && !o_ir;
        t++;
      end
      chk("rand_timeout", int'(t < 400), 1);
      if (t >= 400) hit_reset();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
